// File: rtl/mem_pkg.sv
// Shared definitions for the memory BIST controller: default geometry and
// the controller state encoding.
// Optional feature macro: MEM_BIST_ERRLOG_EN (mismatch counter and first
// failing address).
package mem_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } bist_state_e;

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-data checker for the memory BIST controller. It holds the expected
// word and a valid bit for each read issued by the controller, then compares
// them against the RAM read data one cycle later. A sticky flag records any
// mismatch of the current run.
// With MEM_BIST_ERRLOG_EN defined it also counts mismatches and latches the
// address of the first failing word.
module mem_bist_cmp
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,        // start edge: forget the previous run
    input  logic              rd_valid,     // a read address is on the RAM bus this cycle
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] seed,
    input  logic [DATA_W-1:0] ram_dataout,
    output logic              fail_any      // mismatch seen so far, including this cycle
`ifdef MEM_BIST_ERRLOG_EN
    ,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
`endif
);

    logic              exp_vld;
    logic [DATA_W-1:0] exp_data;
    logic              mism_flag;
    logic              mism_now;

    // The RAM returns data for the address seen on the bus in the previous
    // cycle, so the comparison runs against the registered expectation.
    assign mism_now = exp_vld && (ram_dataout != exp_data);
    assign fail_any = mism_flag | mism_now;

    // Expected-data pipeline: one stage, aligned with the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_vld  <= 1'b0;
            exp_data <= '0;
        end else begin
            exp_vld  <= rd_valid;
            exp_data <= DATA_W'(rd_addr) ^ seed;
        end
    end

    // Sticky mismatch flag, cleared when a new run starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mism_flag <= 1'b0;
        end else if (clear) begin
            mism_flag <= 1'b0;
        end else if (mism_now) begin
            mism_flag <= 1'b1;
        end
    end

`ifdef MEM_BIST_ERRLOG_EN
    logic [ADDR_W-1:0] exp_addr;

    // Address of the word held in the expectation stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_addr <= '0;
        end else begin
            exp_addr <= rd_addr;
        end
    end

    // Error log: at most DEPTH mismatches per run, so the counter cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (clear) begin
            err_count      <= '0;
            first_err_addr <= '0;
        end else if (mism_now) begin
            err_count <= err_count + (ADDR_W+1)'(1);
            if (err_count == '0) begin
                first_err_addr <= exp_addr;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes addr ^ seed to every word, reads every word
// back, and reports pass/fail through a one-cycle done pulse.
// Optional feature macro: MEM_BIST_ERRLOG_EN adds err_count and
// first_err_addr.
//
// Handshake: start is a request sampled only while the FSM is in IDLE; the
// edge that samples it raises busy, latches seed and clears pass. busy stays
// high until the cycle carrying the done pulse, and start is ignored while
// the run is in progress. done rises 2*DEPTH+2 cycles after the sampling
// edge, together with the updated pass (and error log).
module mem_bist_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_datain,
    input  logic [DATA_W-1:0] ram_dataout,
    output bist_state_e       dbg_state
`ifdef MEM_BIST_ERRLOG_EN
    ,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_addr
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    bist_state_e       state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] seed_q;
    logic              rd_q;
    logic              run_start;
    logic              fail_any;

    assign run_start = (state == ST_IDLE) && start;
    assign dbg_state = state;

    // Controller FSM; every RAM-side output is registered from the current
    // state and address, so the bus lags the state register by one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            addr        <= '0;
            seed_q      <= '0;
            rd_q        <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            ram_en      <= 1'b0;
            ram_address <= '0;
            ram_datain  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    ram_en      <= 1'b0;
                    ram_address <= '0;
                    ram_datain  <= '0;
                    rd_q        <= 1'b0;
                    busy        <= 1'b0;
                    if (start) begin
                        state  <= ST_WRITE;
                        addr   <= '0;
                        seed_q <= seed;
                        pass   <= 1'b0;
                        busy   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    busy        <= 1'b1;
                    ram_en      <= 1'b1;
                    ram_address <= addr;
                    ram_datain  <= DATA_W'(addr) ^ seed_q;
                    rd_q        <= 1'b0;
                    if (addr == LAST_ADDR) begin
                        addr  <= '0;
                        state <= ST_READ;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                ST_READ: begin
                    busy        <= 1'b1;
                    ram_en      <= 1'b0;
                    ram_address <= addr;
                    ram_datain  <= '0;
                    rd_q        <= 1'b1;
                    if (addr == LAST_ADDR) begin
                        addr  <= '0;
                        state <= ST_DRAIN;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Let the last read come back from the RAM.
                    busy        <= 1'b1;
                    ram_en      <= 1'b0;
                    ram_address <= '0;
                    ram_datain  <= '0;
                    rd_q        <= 1'b0;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    // fail_any already includes the final compare.
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    pass        <= ~fail_any;
                    ram_en      <= 1'b0;
                    ram_address <= '0;
                    ram_datain  <= '0;
                    rd_q        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    mem_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_cmp (
        .clk            (clk),
        .rst_n          (rst_n),
        .clear          (run_start),
        .rd_valid       (rd_q),
        .rd_addr        (ram_address),
        .seed           (seed_q),
        .ram_dataout    (ram_dataout),
        .fail_any       (fail_any)
`ifdef MEM_BIST_ERRLOG_EN
        ,
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
`endif
    );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Testbench for mem_bist_ctrl with a 1K x 8 synchronous RAM model that can
// hold bit 0 of address 10'h101 stuck at 0.
module tb_mem_bist_ctrl;
    import mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic [7:0]  seed = 8'h00;
    logic        busy, done, pass, ram_en;
    logic [9:0]  ram_address;
    logic [7:0]  ram_datain;
    logic [7:0]  ram_dataout;
    bist_state_e dbg_state;
`ifdef MEM_BIST_ERRLOG_EN
    logic [10:0] err_count;
    logic [9:0]  first_err_addr;
`endif

    mem_bist_ctrl #(
        .ADDR_W (10),
        .DATA_W (8),
        .DEPTH  (1024)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .seed           (seed),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .ram_en         (ram_en),
        .ram_address    (ram_address),
        .ram_datain     (ram_datain),
        .ram_dataout    (ram_dataout),
        .dbg_state      (dbg_state)
`ifdef MEM_BIST_ERRLOG_EN
        ,
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
`endif
    );

    // ---------------- RAM model ----------------
    logic [7:0] mem [0:1023];
    bit         fault_en = 1'b0;
    logic [7:0] w3 = 8'h00;
    logic [7:0] w3ff = 8'h00;

    always @(posedge clk) begin
        if (ram_en) begin
            mem[ram_address] <= ram_datain;
        end
        if (fault_en && ram_address == 10'h101) begin
            ram_dataout <= mem[ram_address] & 8'hFE;
        end else begin
            ram_dataout <= mem[ram_address];
        end
    end

    // Capture the data written to two probe addresses.
    always @(posedge clk) begin
        if (ram_en && ram_address == 10'h003) w3 <= ram_datain;
        if (ram_en && ram_address == 10'h3FF) w3ff <= ram_datain;
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [7:0] s);
        @(negedge clk);
        seed  = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the current point until done is seen high.
    task automatic wait_done(output int lat);
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int c = 1; c <= 3000; c++) begin
            if (!seen) begin
                @(posedge clk);
                #1;
                if (done) begin
                    seen = 1'b1;
                    lat  = c;
                end
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: no done pulse within 3000 cycles");
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " busy"},        32'(busy),        32'd0);
        check({tag, " done"},        32'(done),        32'd0);
        check({tag, " pass"},        32'(pass),        32'd0);
        check({tag, " ram_en"},      32'(ram_en),      32'd0);
        check({tag, " ram_address"}, 32'(ram_address), 32'd0);
        check({tag, " ram_datain"},  32'(ram_datain),  32'd0);
        check({tag, " state"},       32'(dbg_state),   32'(ST_IDLE));
`ifdef MEM_BIST_ERRLOG_EN
        check({tag, " err_count"},   32'(err_count),      32'd0);
        check({tag, " first_err"},   32'(first_err_addr), 32'd0);
`endif
    endtask

    // ---------------- stimulus table ----------------
    typedef struct {
        logic [7:0]  seed;
        bit          fault;
        int          lat;
        logic        pass;
        logic [10:0] errs;
        logic [9:0]  first;
        logic [7:0]  w3;
        logic [7:0]  w3ff;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int cnt;
        bit found;

        vecs[0] = '{seed: 8'h00, fault: 1'b0, lat: 2050, pass: 1'b1, errs: 11'd0, first: 10'h000, w3: 8'h03, w3ff: 8'hFF};
        vecs[1] = '{seed: 8'h00, fault: 1'b1, lat: 2050, pass: 1'b0, errs: 11'd1, first: 10'h101, w3: 8'h03, w3ff: 8'hFF};
        vecs[2] = '{seed: 8'hA5, fault: 1'b0, lat: 2050, pass: 1'b1, errs: 11'd0, first: 10'h000, w3: 8'hA6, w3ff: 8'h5A};
        vecs[3] = '{seed: 8'h3C, fault: 1'b0, lat: 2050, pass: 1'b1, errs: 11'd0, first: 10'h000, w3: 8'h3F, w3ff: 8'hC3};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven runs.
        for (int i = 0; i < 4; i++) begin
            fault_en = vecs[i].fault;
            do_start(vecs[i].seed);
            check($sformatf("vec%0d busy after start", i), 32'(busy), 32'd1);
            check($sformatf("vec%0d pass cleared", i),     32'(pass), 32'd0);
            wait_done(lat);
            check($sformatf("vec%0d latency", i),     32'(lat),  32'(vecs[i].lat));
            check($sformatf("vec%0d pass", i),        32'(pass), 32'(vecs[i].pass));
            check($sformatf("vec%0d busy at done", i), 32'(busy), 32'd0);
            check($sformatf("vec%0d write 0x003", i), 32'(w3),   32'(vecs[i].w3));
            check($sformatf("vec%0d write 0x3FF", i), 32'(w3ff), 32'(vecs[i].w3ff));
`ifdef MEM_BIST_ERRLOG_EN
            check($sformatf("vec%0d err_count", i),      32'(err_count),      32'(vecs[i].errs));
            check($sformatf("vec%0d first_err_addr", i), 32'(first_err_addr), 32'(vecs[i].first));
`endif
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done one cycle", i), 32'(done), 32'd0);
            check($sformatf("vec%0d pass held", i),      32'(pass), 32'(vecs[i].pass));
            check($sformatf("vec%0d back to idle", i),   32'(dbg_state), 32'(ST_IDLE));
        end
        fault_en = 1'b0;

        // Reset pulsed while reading address 0x200.
        do_start(8'h00);
        found = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!found) begin
                @(posedge clk);
                #1;
                if (busy && !ram_en && ram_address == 10'h200) found = 1'b1;
            end
        end
        check("mid-run read 0x200 reached", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (ram_en || busy) cnt++;
        end
        check("idle after reset", 32'(cnt), 32'd0);
        do_start(8'h00);
        wait_done(lat);
        check("post-reset latency", 32'(lat), 32'd2050);
        check("post-reset pass",    32'(pass), 32'd1);

        // Second start pulse during WRITE is ignored.
        do_start(8'h00);
        repeat (10) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("retrigger in write state", 32'(dbg_state), 32'(ST_WRITE));
        wait_done(lat);
        check("retrigger latency", 32'(lat + 11), 32'd2050);
        cnt = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (done) cnt++;
        end
        check("retrigger single done", 32'(cnt), 32'd0);

        // start held high: back-to-back runs with one IDLE cycle between.
        @(negedge clk);
        seed  = 8'h5A;
        start = 1'b1;
        @(posedge clk);
        #1;
        wait_done(lat);
        check("held start run1 latency", 32'(lat), 32'd2050);
        check("held start run1 pass",    32'(pass), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("held start restarts", 32'(dbg_state), 32'(ST_WRITE));
        check("held start busy",     32'(busy), 32'd1);
        check("held start pass clr", 32'(pass), 32'd0);
        wait_done(lat);
        check("held start run2 latency", 32'(lat), 32'd2050);
        check("held start run2 pass",    32'(pass), 32'd1);
        cnt = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (busy) cnt++;
        end
        check("no third run", 32'(cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
